// File: rtl/moving_average_ctrl_if.sv
// Configuration handshake between a window-size requester and the moving-average controller.
interface moving_average_ctrl_if #(
  parameter int SIZE_WINDOW = 7
);
  logic                   cfg_valid;
  logic [SIZE_WINDOW-1:0] cfg_window;
  logic                   cfg_ready;
  logic                   cfg_err;

  modport master (
    output cfg_valid,
    output cfg_window,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_window,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/moving_average_ctrl.sv
// Moving-average window controller: flushes the delay line with zeros, refills it,
// then enables the datapath output whenever a new legal window size is accepted.
module moving_average_ctrl #(
  parameter int SIZE_WINDOW     = 7,
  parameter int SIZE_MAX_WINDOW = 64,
  parameter int PIPE_LAT        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  moving_average_ctrl_if.slave   cfg,
  output logic [SIZE_WINDOW-1:0] window_set,
  output logic                   data_zero,
  output logic                   enable,
  output logic                   busy
);

  localparam int CNT_W     = $clog2(SIZE_MAX_WINDOW + PIPE_LAT + 1);
  localparam int FLUSH_LEN = SIZE_MAX_WINDOW + PIPE_LAT;
  localparam int LIMIT     = (SIZE_MAX_WINDOW < 64) ? SIZE_MAX_WINDOW : 64;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    FILL,
    RUN
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [CNT_W-1:0]       count_inc;
  logic [SIZE_WINDOW-1:0] window_next;
  logic                   err_next;
  logic                   accept;
  logic                   legal;
  logic                   flush_done;
  logic                   fill_done;

  // Ready depends on state only, so a requester may hold valid across busy periods.
  assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    legal = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if ((int'(cfg.cfg_window) == (1 << i)) && ((1 << i) <= LIMIT)) begin
        legal = 1'b1;
      end
    end
  end

  assign count_inc  = (count == '1) ? count : count + CNT_W'(1);
  assign flush_done = (int'(count) == FLUSH_LEN - 1);
  assign fill_done  = (int'(count) == int'(window_set) + PIPE_LAT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    window_next = window_set;
    err_next    = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (legal) begin
            window_next = cfg.cfg_window;
            count_next  = '0;
            state_next  = FLUSH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_next = FILL;
          count_next = '0;
        end else begin
          count_next = count_inc;
        end
      end
      FILL: begin
        if (fill_done) begin
          state_next = RUN;
          count_next = '0;
        end else begin
          count_next = count_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      window_set  <= SIZE_WINDOW'(1);
      cfg.cfg_err <= 1'b0;
      enable      <= 1'b0;
      data_zero   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      count       <= count_next;
      window_set  <= window_next;
      cfg.cfg_err <= err_next;
      enable      <= (state_next == RUN);
      data_zero   <= (state_next == IDLE) || (state_next == FLUSH);
      busy        <= (state_next == FLUSH) || (state_next == FILL);
    end
  end

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Scoreboard bench for moving_average_ctrl: each request queues its expected outcome,
// which is popped and checked against the flush/fill/run behaviour that follows.
`timescale 1ns/100ps
module tb_moving_average_ctrl;

  localparam int SW           = 7;
  localparam int SMW          = 64;
  localparam int PL           = 4;
  localparam int FLUSH_CYCLES = SMW + PL;

  typedef struct {
    int window;
    bit legal;
    int exp_window;
    bit exp_enable;
    bit exp_zero;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [SW-1:0] window_set;
  logic          data_zero;
  logic          enable;
  logic          busy;

  exp_t sb[$];
  int   checks      = 0;
  int   errors      = 0;
  int   model_window = 1;
  bit   model_run    = 0;
  int   waited;

  moving_average_ctrl_if #(.SIZE_WINDOW(SW)) cfg_bus ();

  moving_average_ctrl #(
    .SIZE_WINDOW    (SW),
    .SIZE_MAX_WINDOW(SMW),
    .PIPE_LAT       (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg       (cfg_bus),
    .window_set(window_set),
    .data_zero (data_zero),
    .enable    (enable),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit isLegal(input int w);
    int allowed[7] = '{1, 2, 4, 8, 16, 32, 64};
    isLegal = 1'b0;
    foreach (allowed[k]) begin
      if (w == allowed[k] && allowed[k] <= SMW) isLegal = 1'b1;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge right after acceptance.
  task automatic applyStimulus(input int win, input int hold_win, output int wait_cycles);
    exp_t e;
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_window = SW'(win);
    wait_cycles = 0;
    while (cfg_bus.cfg_ready !== 1'b1 && wait_cycles < 400) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (wait_cycles >= 400) checkOutput("accept_timeout", 0, 1);
    e.window = win;
    e.legal  = isLegal(win);
    if (e.legal) begin
      e.exp_window = win;
      e.exp_enable = 1'b0;
      e.exp_zero   = 1'b1;
    end else begin
      e.exp_window = model_window;
      e.exp_enable = model_run;
      e.exp_zero   = !model_run;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (hold_win >= 0) begin
      cfg_bus.cfg_window = SW'(hold_win);
    end else begin
      cfg_bus.cfg_valid  = 1'b0;
      cfg_bus.cfg_window = SW'($urandom);
    end
  endtask

  task automatic collectResult();
    exp_t e;
    int flush_n, fill_n, ready_busy, ws_changes, guard;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!e.legal) begin
      checkOutput("err_pulse", cfg_bus.cfg_err, 1);
      checkOutput("err_window_hold", window_set, e.exp_window);
      checkOutput("err_enable_hold", enable, e.exp_enable);
      checkOutput("err_zero_hold", data_zero, e.exp_zero);
      checkOutput("err_busy", busy, 0);
      @(negedge clk);
      checkOutput("err_one_cycle", cfg_bus.cfg_err, 0);
      checkOutput("err_state_hold", enable, e.exp_enable);
      checkOutput("err_ready", cfg_bus.cfg_ready, 1);
    end else begin
      checkOutput("accept_window", window_set, e.exp_window);
      checkOutput("accept_enable_off", enable, 0);
      checkOutput("accept_no_err", cfg_bus.cfg_err, 0);
      flush_n = 0; fill_n = 0; ready_busy = 0; ws_changes = 0; guard = 0;
      while (busy === 1'b1 && data_zero === 1'b1 && enable === 1'b0 && guard < 300) begin
        if (cfg_bus.cfg_ready !== 1'b0) ready_busy++;
        if (window_set !== SW'(e.window)) ws_changes++;
        flush_n++; guard++;
        @(negedge clk);
      end
      while (busy === 1'b1 && data_zero === 1'b0 && enable === 1'b0 && guard < 300) begin
        if (cfg_bus.cfg_ready !== 1'b0) ready_busy++;
        if (window_set !== SW'(e.window)) ws_changes++;
        fill_n++; guard++;
        @(negedge clk);
      end
      checkOutput("flush_len", flush_n, FLUSH_CYCLES);
      checkOutput("fill_len", fill_n, e.window + PL);
      checkOutput("ready_low_busy", ready_busy, 0);
      checkOutput("window_stable", ws_changes, 0);
      checkOutput("run_enable", enable, 1);
      checkOutput("run_zero", data_zero, 0);
      checkOutput("run_busy", busy, 0);
      checkOutput("run_ready", cfg_bus.cfg_ready, 1);
      checkOutput("run_window", window_set, e.window);
      model_window = e.window;
      model_run    = 1'b1;
    end
  endtask

  initial begin
    int g;
    int win;
    reset              = 1'b0;
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_window = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_window", window_set, 1);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_zero", data_zero, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", cfg_bus.cfg_err, 0);
    checkOutput("rst_ready", cfg_bus.cfg_ready, 1);
    reset = 1'b1;

    repeat (3) begin
      cfg_bus.cfg_window = SW'($urandom);
      @(negedge clk);
    end
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_window", window_set, 1);
    checkOutput("idle_enable", enable, 0);

    applyStimulus(0, -1, waited);   collectResult();
    applyStimulus(127, -1, waited); collectResult();
    applyStimulus(8, -1, waited);   collectResult();
    applyStimulus(5, -1, waited);   collectResult();

    repeat (4) begin
      cfg_bus.cfg_window = SW'($urandom);
      @(negedge clk);
      checkOutput("ignore_window", window_set, model_window);
      checkOutput("ignore_enable", enable, 1);
    end

    // Request held through a busy period is taken on the first RUN cycle.
    applyStimulus(32, 16, waited);  collectResult();
    applyStimulus(16, -1, waited);
    checkOutput("held_accept_wait", waited, 0);
    collectResult();
    applyStimulus(64, -1, waited);  collectResult();

    applyStimulus(4, -1, waited);
    sb.delete();
    g = 0;
    while (!(busy === 1'b1 && data_zero === 1'b0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("reached_fill", busy & ~data_zero, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #0.5;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_zero", data_zero, 1);
    checkOutput("async_rst_enable", enable, 0);
    checkOutput("async_rst_window", window_set, 1);
    checkOutput("async_rst_ready", cfg_bus.cfg_ready, 1);
    #0.5 reset = 1'b1;
    model_window = 1;
    model_run    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_enable", enable, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_ready", cfg_bus.cfg_ready, 1);

    applyStimulus(1, -1, waited);   collectResult();

    for (int i = 0; i < 6; i++) begin
      win = (i % 2 == 1) ? (1 << $urandom_range(0, 6)) : int'($urandom_range(0, 127));
      applyStimulus(win, -1, waited);
      collectResult();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moving_average_ctrl.md
MOVING_AVERAGE_CTRL -- requirements
Module: moving_average_ctrl

Interface
REQ-001 Parameter SIZE_WINDOW, default 7, width of window-size fields.
REQ-002 Parameter SIZE_MAX_WINDOW, default 64, largest legal window and depth of the datapath delay line.
REQ-003 Parameter PIPE_LAT, default 4, clocks from a datapath input sample to its effect on the datapath output.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low; when low, all state and outputs are forced to reset values.
REQ-006 cfg_valid  input  1  new window request is present.
REQ-007 cfg_window  input  SIZE_WINDOW  requested window size.
REQ-008 cfg_ready  output  1  controller accepts a request this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse: the accepted request was illegal.
REQ-010 window_set  output  SIZE_WINDOW  active window size driven to the datapath.
REQ-011 data_zero  output  1  datapath input mux forces samples to 0 while high.
REQ-012 enable  output  1  datapath output register update enable.
REQ-013 busy  output  1  high in FLUSH and FILL.

Function
REQ-014 The FSM SHALL have four states: IDLE, FLUSH, FILL and RUN.
REQ-015 cfg_ready SHALL be 1 in IDLE and RUN and 0 in FLUSH and FILL; a request is accepted on a clock edge where cfg_valid and cfg_ready are both 1.
REQ-016 A request is legal only if cfg_window is in {1,2,4,8,16,32,64} and is <= SIZE_MAX_WINDOW.
REQ-017 An illegal accepted request SHALL pulse cfg_err for exactly one cycle on the next cycle and leave state, window_set, enable and data_zero unchanged.
REQ-018 A legal accepted request SHALL, on the same edge, load window_set with cfg_window, clear the counter, and move the FSM to FLUSH.
REQ-019 In FLUSH: data_zero=1 and enable=0 for SIZE_MAX_WINDOW+PIPE_LAT cycles, then the FSM moves to FILL.
REQ-020 In FILL: data_zero=0 and enable=0 for window_set+PIPE_LAT cycles, then the FSM moves to RUN.
REQ-021 In RUN: data_zero=0 and enable=1 until the next legal request is accepted.
REQ-022 A legal request accepted in RUN SHALL deassert enable on the next cycle; the datapath output holds its last value during FLUSH and FILL.
REQ-023 In IDLE: enable=0 and data_zero=1.
REQ-024 The counter width SHALL be clog2(SIZE_MAX_WINDOW+PIPE_LAT+1) bits, and the counter SHALL saturate instead of wrapping.
REQ-025 A counter compare SHALL use the registered window_set, not cfg_window.
REQ-026 busy SHALL be exactly (state==FLUSH or state==FILL).
REQ-027 cfg_window SHALL be ignored when cfg_valid=0 or cfg_ready=0; it may change freely.
REQ-028 All outputs SHALL be registered, with no combinational path from an input to an output.
REQ-028a Exception to REQ-028: cfg_ready, which is decoded from state only.

Reset
REQ-029 While reset=0, the block SHALL force: state=IDLE, window_set=1, counter=0, enable=0, data_zero=1, cfg_err=0, busy=0.
REQ-030 A reset assertion in any state SHALL abort the sequence immediately, without waiting for a clock edge.
REQ-031 After reset deasserts, the FSM SHALL stay in IDLE until a legal request is accepted.

Verification
REQ-032 Reset release, then cfg_window=8 accepted -> busy=1; data_zero=1 for 68 cycles; then 12 cycles with data_zero=0 and enable=0; then enable=1 and cfg_ready=1.
REQ-033 In RUN with window 8, request cfg_window=5 -> cfg_err=1 for one cycle; window_set stays 8; enable stays 1; the state stays RUN.
REQ-034 In FLUSH, hold cfg_valid=1 with cfg_window=16 -> cfg_ready=0 throughout, and there is no acceptance until RUN; on the first RUN cycle the request is accepted and window_set=16.
REQ-035 Assert reset for 1 ns in mid-FILL (off a clock edge) -> the outputs take the reset values immediately; after release the FSM is in IDLE and enable=0.
REQ-036 In IDLE, cfg_window=1 accepted -> FLUSH for 68 cycles, then FILL for 5 cycles, then RUN with window_set=1.
REQ-037 Request cfg_window=0 and cfg_window=127 -> a cfg_err pulse for each request, and no state change.
